wb_ebr_slave: RTL



---
 rtl/wb_ebr_slave.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_ebr_slave.sv
// Wishbone classic slave: a 64-bit byte-lane-writable EBR memory window plus a small
// control/status register window, acked once per access after a fixed number of wait states.
module wb_ebr_slave #(
  parameter int          c_DATA_WIDTH  = 64,
  parameter int          c_ADDR_WIDTH  = 10,
  parameter int          c_WAIT_STATES = 0,
  parameter logic [63:0] c_ID          = 64'h0000_0000_5742_0001
) (
  input  logic                      wb_clk,
  input  logic                      rst,
  input  logic [31:0]               wb_adr_i,
  input  logic [c_DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                      wb_we_i,
  input  logic [c_DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_lock_i,
  output logic                      wb_ack_o,
  output logic [c_DATA_WIDTH-1:0]   wb_dat_o
);

  localparam int         LP_LANES = c_DATA_WIDTH / 8;
  localparam int         LP_DEPTH = 2 ** c_ADDR_WIDTH;
  localparam logic [3:0] LP_WLOAD = (c_WAIT_STATES == 0) ? 4'd0 : 4'(c_WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]              r_state;
  logic [3:0]              r_wcnt;
  logic                    r_ack;
  logic                    r_we;
  logic                    r_win;
  logic [c_ADDR_WIDTH-1:0] r_idx;
  logic [LP_LANES-1:0]     r_sel;
  logic [c_DATA_WIDTH-1:0] r_wdat;
  logic [c_DATA_WIDTH-1:0] r_reg_rd;
  logic [c_DATA_WIDTH-1:0] r_mem_rd;
  logic [c_DATA_WIDTH-1:0] r_scratch;
  logic [63:0]             r_cycles;
  logic [31:0]             r_wrcnt;
  logic [31:0]             r_rdcnt;
  logic [c_DATA_WIDTH-1:0] r_mem [LP_DEPTH];

  logic                    w_accept;
  logic                    w_mem_we;
  logic                    w_cnt_clr;
  logic                    w_win;
  logic [c_ADDR_WIDTH-1:0] w_idx;
  logic [c_ADDR_WIDTH-1:0] w_rd_idx;
  logic [c_DATA_WIDTH-1:0] w_reg_rd;
  logic                    w_unused;

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_idx     = wb_adr_i[c_ADDR_WIDTH+2:3];
  assign w_win     = wb_adr_i[c_ADDR_WIDTH+3];
  assign w_accept  = (r_state == S_IDLE) & wb_cyc_i & wb_stb_i;
  assign w_rd_idx  = w_accept ? w_idx : r_idx;
  assign w_mem_we  = (r_state == S_ACK) & r_we & ~r_win & ~rst;
  assign w_cnt_clr = r_we & r_win & (r_idx[2:1] == 2'b01);
  assign w_unused  = ^{wb_lock_i, wb_adr_i[31:c_ADDR_WIDTH+4], wb_adr_i[2:0]};

  always_comb begin
    w_reg_rd = '0;
    case (w_idx[2:0])
      3'd0:    w_reg_rd = c_DATA_WIDTH'(c_ID);
      3'd1:    w_reg_rd = r_scratch;
      3'd2:    w_reg_rd = c_DATA_WIDTH'(r_wrcnt);
      3'd3:    w_reg_rd = c_DATA_WIDTH'(r_rdcnt);
      3'd4:    w_reg_rd = c_DATA_WIDTH'(r_cycles);
      default: w_reg_rd = '0;
    endcase
  end

  // Single-port EBR: the read address follows the bus on accept, then holds the latched word.
  always_ff @(posedge wb_clk) begin
    for (int i = 0; i < LP_LANES; i++) begin
      if (w_mem_we && r_sel[i]) r_mem[r_idx][8*i +: 8] <= r_wdat[8*i +: 8];
    end
    r_mem_rd <= r_mem[w_rd_idx];
  end

  always_ff @(posedge wb_clk) begin
    if (w_accept) begin
      r_we     <= wb_we_i;
      r_win    <= w_win;
      r_idx    <= w_idx;
      r_sel    <= wb_sel_i;
      r_wdat   <= wb_dat_i;
      r_reg_rd <= w_reg_rd;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_ack     <= 1'b0;
      r_scratch <= '0;
      r_cycles  <= '0;
      r_wrcnt   <= '0;
      r_rdcnt   <= '0;
    end else begin
      r_cycles <= r_cycles + 64'd1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (c_WAIT_STATES == 0) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_wcnt  <= LP_WLOAD;
            end
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
          end else if (r_wcnt == 4'd0) begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          // Clearing takes priority over the increment of the access that requested it.
          if (w_cnt_clr) begin
            r_wrcnt <= '0;
            r_rdcnt <= '0;
          end else if (r_we) begin
            r_wrcnt <= f_sat_inc(r_wrcnt);
          end else begin
            r_rdcnt <= f_sat_inc(r_rdcnt);
          end
          if (r_we && r_win && r_idx[2:0] == 3'd1) begin
            for (int i = 0; i < LP_LANES; i++) begin
              if (r_sel[i]) r_scratch[8*i +: 8] <= r_wdat[8*i +: 8];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_ack ? (r_win ? r_reg_rd : r_mem_rd) : '0;

endmodule
